x1_sub_responder: RTL and testbench
===================================

Name: x1_sub_responder

Overview:
- Sub-CPU side of the main/sub communication port: the responder to the Z80's sub_cs/sub_rd/sub_wr transactions on the X1 top level.
- Receives command bytes and argument bytes from the main CPU, executes them, and returns response bytes through a small read buffer.
- Implements the key-read, time and calendar commands; it replaces the 80C49 firmware path for these services.

Parameters:
- RBUF_DEPTH, 4, response buffer depth in bytes (minimum 3).
- KEY_NONE_MOD, 8'hFF, modifier byte returned when no key is pending.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sub_cs  in  1  chip select from the address decoder (level).
- sub_wr  in  1  main CPU write strobe (level, held over several clk_sys cycles).
- sub_rd  in  1  main CPU read strobe (level).
- sub_di  in  8  byte written by the main CPU.
- sub_do  out  8  byte presented to the main CPU.
- rx_bsy  out  1  1 = responder cannot accept a write.
- tx_bsy  out  1  1 = no response byte available.
- key_valid  in  1  one-cycle pulse: a new key is available.
- key_mod  in  8  modifier byte, sampled on key_valid.
- key_code  in  8  ASCII code, sampled on key_valid.
- tick_1s  in  1  one-cycle pulse, 1 Hz.
- cmd_err  out  1  one-cycle pulse on an unknown command byte.

Behaviour:
- Reset (async, any state) clears the following:
  - outputs: sub_do=00, rx_bsy=0, tx_bsy=1, cmd_err=0;
  - FSM returns to IDLE;
  - response buffer empties; key pending cleared;
  - time regs = 00:00:00 BCD; calendar regs = yy 00, mm 01, dd 01.
- Write accept occurs on the rising edge of (sub_cs & sub_wr), registered, so there is 1 event per strobe however long it is held.
- Read consume occurs on the falling edge of (sub_cs & sub_rd). sub_do must stay stable while the read strobe is high.
- FSM states: IDLE, ARG, EXEC, RESP.
  - IDLE, write of E6/EC/EA goes to EXEC.
  - IDLE, write of ED/EB: latch the command, argument count = 3, go to ARG.
  - IDLE, any other byte: cmd_err pulse, stay in IDLE.
  - ARG: each write stores the next argument byte. After the 3rd argument, go to EXEC.
  - EXEC lasts exactly 1 cycle, with rx_bsy=1. Writes that arrive in EXEC are ignored.
    - E6: load {key_pending ? key_mod : KEY_NONE_MOD, key_pending ? key_code : 00} into the buffer, then clear key_pending.
    - EC: load {hh, mm, ss}.
    - EA: load {yy, mm, dd}.
    - ED: hh/mm/ss take the argument bytes in that order.
    - EB: yy/mm/dd take the argument bytes in that order.
    - Next state is RESP if the buffer is non-empty, otherwise IDLE.
  - RESP: each read consume pops the head byte. When the buffer is empty, go to IDLE.
  - RESP, a write arrives: flush the buffer and treat the byte as a new command from IDLE in the same cycle.
- Latency: command accept to tx_bsy=0 is 2 clk_sys cycles (edge register, then EXEC).
- sub_do = buffer head when the buffer is non-empty, otherwise 00.
- tx_bsy = (buffer empty).
- rx_bsy = 1 only in EXEC.
- Key latch: key_valid sets key_pending and captures key_mod/key_code.
  - A new key while one is pending overwrites the latched key.
  - key_valid in the same cycle as E6 EXEC: the old value is returned and the new key stays pending.
- Clock (BCD):
  - tick_1s increments ss 00..59 with carry into mm; mm 00..59 with carry into hh; hh 00..23 wraps to 00.
  - Calendar does not auto-advance.
  - tick_1s in the same cycle as ED EXEC: the set values win and the tick is dropped.
- Argument bytes are stored unchecked. Non-BCD values increment as binary+1 until the next BCD compare point, and no sanitising is done.
- Read consume with an empty buffer: no effect.
- A read while a write is pending in the same cycle: the write is processed first.

Test Plan:
1. Reset, then write E6 with no key pending → tx_bsy falls 2 cycles later; two reads return FF then 00; tx_bsy=1, FSM in IDLE.
2. key_valid with mod=7F, code=41, then E6 → reads return 7F, 41. A second E6 returns FF, 00.
3. Write ED, 23, 59, 58, then 2 tick_1s pulses, then EC → reads return 00, 00, 00 (hh/mm/ss wrap).
4. Write EB, 24, 12, 31, then EA → reads return 24, 12, 31. A tick_1s leaves the calendar unchanged.
5. Write 55 → cmd_err for 1 cycle, state stays IDLE. Hold sub_wr for 10 cycles on E6 → exactly one command executes.
6. EC issued, 1 byte read, then E6 written in RESP → buffer flushed and the next read returns key data. Assert reset mid-ARG → all outputs return to reset values immediately (async).

Source files
------------

// File: rtl/x1_sub_responder.sv
// x1_sub_responder
// Sub-CPU responder for the X1 main/sub communication port. The main CPU
// writes a command byte (plus argument bytes for set commands); the block
// executes it and offers response bytes through a small read buffer.
//
// Strobe protocol: one write is accepted per rising edge of (sub_cs & sub_wr),
// however long the strobe is held; writes are only honoured while rx_bsy=0.
// A response byte is offered on sub_do whenever tx_bsy=0 and is consumed on
// the falling edge of (sub_cs & sub_rd), so sub_do is stable during the read.
//
// Ports:
//   clk_sys, reset           clock, asynchronous active-high reset
//   sub_cs/sub_wr/sub_rd     main CPU chip select and level strobes
//   sub_di / sub_do          byte from / to the main CPU
//   rx_bsy / tx_bsy          cannot accept a write / no response byte ready
//   key_valid/key_mod/code   key event pulse and its data
//   tick_1s                  1 Hz pulse for the BCD clock
//   cmd_err                  one-cycle pulse on an unknown command byte
//   o_dbg_state              current FSM state (0 IDLE,1 ARG,2 EXEC,3 RESP)
module x1_sub_responder #(
   parameter int          RBUF_DEPTH   = 4,
   parameter logic [7:0]  KEY_NONE_MOD = 8'hFF
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       sub_cs,
   input  logic       sub_wr,
   input  logic       sub_rd,
   input  logic [7:0] sub_di,
   output logic [7:0] sub_do,
   output logic       rx_bsy,
   output logic       tx_bsy,
   input  logic       key_valid,
   input  logic [7:0] key_mod,
   input  logic [7:0] key_code,
   input  logic       tick_1s,
   output logic       cmd_err,
   output logic [1:0] o_dbg_state
);

   localparam int CW = $clog2(RBUF_DEPTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARG  = 2'd1,
      ST_EXEC = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   state_t        r_state;
   logic          r_wr_d, r_wr_ev, r_rd_d, r_cmd_err;
   logic [7:0]    r_wr_byte, r_cmd;
   logic [7:0]    r_arg0, r_arg1, r_arg2;
   logic [1:0]    r_arg_cnt;
   logic [7:0]    r_buf [RBUF_DEPTH];
   logic [CW-1:0] r_cnt;
   logic          r_key_pend;
   logic [7:0]    r_key_mod, r_key_code;
   logic [7:0]    r_hh, r_mi, r_ss, r_yy, r_mo, r_dd;

   logic w_wr, w_rd, w_rd_fall, w_new_cmd, w_exec_e6, w_exec_ed, w_exec_eb;

   assign w_wr      = sub_cs & sub_wr;
   assign w_rd      = sub_cs & sub_rd;
   assign w_rd_fall = r_rd_d & ~w_rd;
   // A write in RESP flushes the buffer and is decoded exactly as in IDLE.
   assign w_new_cmd = r_wr_ev & ((r_state == ST_IDLE) | (r_state == ST_RESP));
   assign w_exec_e6 = (r_state == ST_EXEC) & (r_cmd == 8'hE6);
   assign w_exec_ed = (r_state == ST_EXEC) & (r_cmd == 8'hED);
   assign w_exec_eb = (r_state == ST_EXEC) & (r_cmd == 8'hEB);

   assign sub_do      = (r_cnt != '0) ? r_buf[0] : 8'h00;
   assign tx_bsy      = (r_cnt == '0);
   assign rx_bsy      = (r_state == ST_EXEC);
   assign cmd_err     = r_cmd_err;
   assign o_dbg_state = r_state;

   // BCD increment with wrap at vmax; non-BCD values simply count up in
   // binary until they hit a compare point.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] vmax);
      if (v == vmax)            return 8'h00;
      else if (v[3:0] == 4'h9)  return {v[7:4] + 4'd1, 4'h0};
      else                      return v + 8'd1;
   endfunction

   // Strobe edge detection; the write event is registered with its byte.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_wr_d    <= 1'b0;
         r_wr_ev   <= 1'b0;
         r_wr_byte <= 8'h00;
         r_rd_d    <= 1'b0;
      end else begin
         r_wr_d  <= w_wr;
         r_wr_ev <= w_wr & ~r_wr_d;
         r_rd_d  <= w_rd;
         if (w_wr & ~r_wr_d) r_wr_byte <= sub_di;
      end
   end

   // Command FSM and response buffer (head at index 0).
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_cmd     <= 8'h00;
         r_cmd_err <= 1'b0;
         r_arg0    <= 8'h00;
         r_arg1    <= 8'h00;
         r_arg2    <= 8'h00;
         r_arg_cnt <= 2'd0;
         r_cnt     <= '0;
         for (int i = 0; i < RBUF_DEPTH; i++) r_buf[i] <= 8'h00;
      end else begin
         r_cmd_err <= 1'b0;
         if (w_new_cmd) begin
            r_cnt <= '0;
            r_cmd <= r_wr_byte;
            case (r_wr_byte)
               8'hE6, 8'hEC, 8'hEA: r_state <= ST_EXEC;
               8'hED, 8'hEB: begin
                  r_state   <= ST_ARG;
                  r_arg_cnt <= 2'd0;
               end
               default: begin
                  r_cmd_err <= 1'b1;
                  r_state   <= ST_IDLE;
               end
            endcase
         end else begin
            case (r_state)
               ST_ARG: begin
                  if (r_wr_ev) begin
                     // Shift in so that r_arg0 ends up holding the first byte.
                     r_arg0 <= r_arg1;
                     r_arg1 <= r_arg2;
                     r_arg2 <= r_wr_byte;
                     if (r_arg_cnt == 2'd2) r_state <= ST_EXEC;
                     else                   r_arg_cnt <= r_arg_cnt + 2'd1;
                  end
               end
               ST_EXEC: begin
                  for (int i = 0; i < RBUF_DEPTH; i++) r_buf[i] <= 8'h00;
                  case (r_cmd)
                     8'hE6: begin
                        r_buf[0] <= r_key_pend ? r_key_mod  : KEY_NONE_MOD;
                        r_buf[1] <= r_key_pend ? r_key_code : 8'h00;
                        r_cnt    <= CW'(2);
                        r_state  <= ST_RESP;
                     end
                     8'hEC: begin
                        r_buf[0] <= r_hh;
                        r_buf[1] <= r_mi;
                        r_buf[2] <= r_ss;
                        r_cnt    <= CW'(3);
                        r_state  <= ST_RESP;
                     end
                     8'hEA: begin
                        r_buf[0] <= r_yy;
                        r_buf[1] <= r_mo;
                        r_buf[2] <= r_dd;
                        r_cnt    <= CW'(3);
                        r_state  <= ST_RESP;
                     end
                     default: begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                     end
                  endcase
               end
               ST_RESP: begin
                  if (w_rd_fall) begin
                     for (int i = 0; i < RBUF_DEPTH - 1; i++) r_buf[i] <= r_buf[i+1];
                     r_buf[RBUF_DEPTH-1] <= 8'h00;
                     r_cnt <= r_cnt - CW'(1);
                     if (r_cnt == CW'(1)) r_state <= ST_IDLE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Key latch: a new key during E6 execution stays pending for the next E6.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_key_pend <= 1'b0;
         r_key_mod  <= 8'h00;
         r_key_code <= 8'h00;
      end else if (key_valid) begin
         r_key_pend <= 1'b1;
         r_key_mod  <= key_mod;
         r_key_code <= key_code;
      end else if (w_exec_e6) begin
         r_key_pend <= 1'b0;
      end
   end

   // BCD time of day; a set in the same cycle as a tick drops the tick.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_hh <= 8'h00;
         r_mi <= 8'h00;
         r_ss <= 8'h00;
      end else if (w_exec_ed) begin
         r_hh <= r_arg0;
         r_mi <= r_arg1;
         r_ss <= r_arg2;
      end else if (tick_1s) begin
         r_ss <= bcd_inc(r_ss, 8'h59);
         if (r_ss == 8'h59) begin
            r_mi <= bcd_inc(r_mi, 8'h59);
            if (r_mi == 8'h59) r_hh <= bcd_inc(r_hh, 8'h23);
         end
      end
   end

   // Calendar only changes when set.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_yy <= 8'h00;
         r_mo <= 8'h01;
         r_dd <= 8'h01;
      end else if (w_exec_eb) begin
         r_yy <= r_arg0;
         r_mo <= r_arg1;
         r_dd <= r_arg2;
      end
   end

endmodule

// File: tb/tb_x1_sub_responder.sv
// Bench for x1_sub_responder: directed steps plus randomized time/key/calendar
// traffic, checked against a seconds-of-day / queue reference model.
module tb_x1_sub_responder;

   logic       clk_sys = 1'b0;
   logic       reset;
   logic       sub_cs, sub_wr, sub_rd;
   logic [7:0] sub_di, sub_do;
   logic       rx_bsy, tx_bsy;
   logic       key_valid;
   logic [7:0] key_mod, key_code;
   logic       tick_1s;
   logic       cmd_err;
   logic [1:0] o_dbg_state;

   x1_sub_responder #(.RBUF_DEPTH(4), .KEY_NONE_MOD(8'hFF)) dut (
      .clk_sys(clk_sys), .reset(reset),
      .sub_cs(sub_cs), .sub_wr(sub_wr), .sub_rd(sub_rd),
      .sub_di(sub_di), .sub_do(sub_do),
      .rx_bsy(rx_bsy), .tx_bsy(tx_bsy),
      .key_valid(key_valid), .key_mod(key_mod), .key_code(key_code),
      .tick_1s(tick_1s), .cmd_err(cmd_err), .o_dbg_state(o_dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk_sys = ~clk_sys;

   // ---------------- reference model ----------------
   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] exp_q[$];
   int         m_secs;                 // seconds since midnight
   logic [7:0] m_yy, m_mo, m_dd;
   bit         m_pend;
   logic [7:0] m_mod, m_code;

   function automatic logic [7:0] to_bcd(input int v);
      return 8'(((v / 10) * 16) + (v % 10));
   endfunction

   task automatic model_reset();
      m_secs = 0;
      m_yy = 8'h00; m_mo = 8'h01; m_dd = 8'h01;
      m_pend = 1'b0; m_mod = 8'h00; m_code = 8'h00;
      exp_q.delete();
   endtask

   task automatic model_e6();
      if (m_pend) begin exp_q.push_back(m_mod); exp_q.push_back(m_code); end
      else        begin exp_q.push_back(8'hFF); exp_q.push_back(8'h00); end
      m_pend = 1'b0;
   endtask

   task automatic model_ec();
      exp_q.push_back(to_bcd(m_secs / 3600));
      exp_q.push_back(to_bcd((m_secs / 60) % 60));
      exp_q.push_back(to_bcd(m_secs % 60));
   endtask

   task automatic model_ea();
      exp_q.push_back(m_yy); exp_q.push_back(m_mo); exp_q.push_back(m_dd);
   endtask

   // ---------------- scoreboard check ----------------
   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic wr(input logic [7:0] b, input int hold);
      @(negedge clk_sys);
      sub_cs = 1'b1; sub_wr = 1'b1; sub_di = b;
      repeat (hold) @(negedge clk_sys);
      sub_cs = 1'b0; sub_wr = 1'b0;
   endtask

   task automatic settle();
      repeat (3) @(negedge clk_sys);
   endtask

   task automatic rd(output logic [7:0] b);
      @(negedge clk_sys);
      sub_cs = 1'b1; sub_rd = 1'b1;
      @(negedge clk_sys);
      b = sub_do;
      sub_cs = 1'b0; sub_rd = 1'b0;
      @(negedge clk_sys);
   endtask

   task automatic key(input logic [7:0] md, input logic [7:0] cd);
      @(negedge clk_sys);
      key_valid = 1'b1; key_mod = md; key_code = cd;
      @(negedge clk_sys);
      key_valid = 1'b0;
      m_pend = 1'b1; m_mod = md; m_code = cd;
   endtask

   task automatic tick();
      @(negedge clk_sys);
      tick_1s = 1'b1;
      @(negedge clk_sys);
      tick_1s = 1'b0;
      m_secs = (m_secs + 1) % 86400;
   endtask

   task automatic do_e6(input int hold);
      wr(8'hE6, hold); model_e6(); settle();
   endtask

   task automatic do_ec();
      wr(8'hEC, 1); model_ec(); settle();
   endtask

   task automatic do_ea();
      wr(8'hEA, 1); model_ea(); settle();
   endtask

   task automatic do_ed(input int h, input int m, input int s);
      wr(8'hED, 1); wr(to_bcd(h), 1); wr(to_bcd(m), 1); wr(to_bcd(s), 1);
      m_secs = h * 3600 + m * 60 + s;
      settle();
   endtask

   task automatic do_eb(input logic [7:0] y, input logic [7:0] mo, input logic [7:0] d);
      wr(8'hEB, 1); wr(y, 1); wr(mo, 1); wr(d, 1);
      m_yy = y; m_mo = mo; m_dd = d;
      settle();
   endtask

   // Read out every expected byte, then the port must be idle and empty.
   task automatic drain(input string tag);
      logic [7:0] b;
      while (exp_q.size() > 0) begin
         check({tag, "_txrdy"}, {7'd0, tx_bsy}, 8'h00);
         rd(b);
         check({tag, "_data"}, b, exp_q.pop_front());
      end
      check({tag, "_txbsy"}, {7'd0, tx_bsy}, 8'h01);
      check({tag, "_idle"}, {6'd0, o_dbg_state}, 8'h00);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_do"},    sub_do, 8'h00);
      check({tag, "_rx"},    {7'd0, rx_bsy}, 8'h00);
      check({tag, "_tx"},    {7'd0, tx_bsy}, 8'h01);
      check({tag, "_err"},   {7'd0, cmd_err}, 8'h00);
      check({tag, "_state"}, {6'd0, o_dbg_state}, 8'h00);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [7:0] b;
      reset = 1'b1;
      sub_cs = 1'b0; sub_wr = 1'b0; sub_rd = 1'b0; sub_di = 8'h00;
      key_valid = 1'b0; key_mod = 8'h00; key_code = 8'h00; tick_1s = 1'b0;
      model_reset();
      repeat (3) @(negedge clk_sys);
      check_reset_outputs("rst");
      reset = 1'b0;
      @(negedge clk_sys);

      // 1: E6 with no key, exact two-cycle latency
      @(negedge clk_sys);
      sub_cs = 1'b1; sub_wr = 1'b1; sub_di = 8'hE6;
      @(negedge clk_sys);
      sub_cs = 1'b0; sub_wr = 1'b0;
      check("lat0_tx", {7'd0, tx_bsy}, 8'h01);
      check("lat0_rx", {7'd0, rx_bsy}, 8'h00);
      @(negedge clk_sys);
      check("lat1_rx", {7'd0, rx_bsy}, 8'h01);
      check("lat1_tx", {7'd0, tx_bsy}, 8'h01);
      @(negedge clk_sys);
      check("lat2_tx", {7'd0, tx_bsy}, 8'h00);
      check("lat2_rx", {7'd0, rx_bsy}, 8'h00);
      model_e6();
      drain("t1");

      // 2: pending key returned once
      key(8'h7F, 8'h41);
      do_e6(1); drain("t2a");
      do_e6(1); drain("t2b");

      // 3: set 23:59:58, two ticks wrap to midnight
      do_ed(23, 59, 58);
      tick(); tick();
      do_ec(); drain("t3");

      // 4: calendar set and read; ticks do not advance it
      do_eb(8'h24, 8'h12, 8'h31);
      do_ea(); drain("t4a");
      tick();
      do_ea(); drain("t4b");

      // 5: unknown command pulses cmd_err for exactly one cycle
      wr(8'h55, 1);
      @(negedge clk_sys);
      check("err_pulse", {7'd0, cmd_err}, 8'h01);
      check("err_state", {6'd0, o_dbg_state}, 8'h00);
      @(negedge clk_sys);
      check("err_clear", {7'd0, cmd_err}, 8'h00);
      // long write strobe executes a single E6 (a second run would lose the key)
      key(8'h12, 8'h34);
      do_e6(10); drain("t5");

      // key arriving in the E6 execute cycle stays pending
      key(8'h01, 8'h02);
      wr(8'hE6, 1);
      @(negedge clk_sys);
      key_valid = 1'b1; key_mod = 8'hA5; key_code = 8'h5A;
      @(negedge clk_sys);
      key_valid = 1'b0;
      model_e6();
      m_pend = 1'b1; m_mod = 8'hA5; m_code = 8'h5A;
      settle(); drain("kv_exec_a");
      do_e6(1); drain("kv_exec_b");

      // tick in the ED execute cycle is dropped
      wr(8'hED, 1); wr(8'h10, 1); wr(8'h20, 1); wr(8'h30, 1);
      @(negedge clk_sys);
      tick_1s = 1'b1;
      @(negedge clk_sys);
      tick_1s = 1'b0;
      m_secs = 10 * 3600 + 20 * 60 + 30;
      settle();
      do_ec(); drain("tick_exec");

      // 6: write in RESP flushes and starts a new command
      do_ec();
      rd(b);
      check("resp_first", b, exp_q.pop_front());
      key(8'h3C, 8'h61);
      wr(8'hE6, 1);
      exp_q.delete();
      model_e6();
      settle(); drain("resp_flush");

      // async reset in the middle of ARG
      wr(8'hED, 1); wr(8'h11, 1);
      @(negedge clk_sys);
      check("arg_state", {6'd0, o_dbg_state}, 8'h01);
      #2 reset = 1'b1;
      #1 check_reset_outputs("rst_arg");
      @(negedge clk_sys);
      reset = 1'b0;
      model_reset();
      // async reset while response bytes are waiting
      do_ea();
      check("pre_rst_tx", {7'd0, tx_bsy}, 8'h00);
      #2 reset = 1'b1;
      #1 check_reset_outputs("rst_resp");
      @(negedge clk_sys);
      reset = 1'b0;
      model_reset();
      do_ec(); drain("post_rst_time");
      do_ea(); drain("post_rst_cal");

      // randomized traffic
      for (int it = 0; it < 6; it++) begin
         int h, m, s, nt;
         h  = $urandom_range(0, 23);
         m  = $urandom_range(0, 59);
         s  = $urandom_range(0, 59);
         if (it % 2 == 0) begin m = 59; s = $urandom_range(40, 59); end
         nt = $urandom_range(0, 75);
         do_ed(h, m, s);
         repeat (nt) tick();
         do_ec(); drain("rnd_time");
         if ($urandom_range(0, 1) == 1) key(8'($urandom), 8'($urandom));
         do_e6($urandom_range(1, 4)); drain("rnd_key");
         do_eb(8'($urandom), 8'($urandom), 8'($urandom));
         do_ea(); drain("rnd_cal");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
